// File: rtl/synth_pkg.sv
// Shared types and default sizing for the keypad-to-synth control plane.
// Contents: wave_t waveform selector, ctrl_state_t envelope gate states,
// default key/octave/release constants used as parameter defaults.
package synth_pkg;

    localparam int unsigned NUM_KEYS_C       = 13;
    localparam int unsigned NUM_OCT_C        = 8;
    localparam int unsigned RELEASE_CYCLES_C = 1024;
    localparam int unsigned DEFAULT_OCT_C    = 4;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        SINE   = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/note_arbiter.sv
// Reduces the pressed-key vector to one active note, last-pressed wins.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   keys_i         : synchronized key levels, 1 = pressed
//   note_o         : registered active note index
//   note_valid_o   : registered "any key held"
module note_arbiter #(
    parameter int unsigned NUM_KEYS = 13,
    parameter int unsigned NOTE_W   = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NOTE_W-1:0]   note_o,
    output logic                note_valid_o
);

    logic [NUM_KEYS-1:0] keys_q;
    logic [NUM_KEYS-1:0] new_press;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                valid_q;

    // Priority: newest press (highest index on a tie), then hold, then lowest held key.
    always_comb begin
        new_press = keys_i & ~keys_q;
        note_d    = note_q;
        if (|new_press) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                if (new_press[i]) note_d = NOTE_W'(i);
            end
        end else if (keys_i[note_q]) begin
            note_d = note_q;
        end else if (|keys_i) begin
            for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
                if (keys_i[i]) note_d = NOTE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            keys_q  <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            keys_q  <= keys_i;
            note_q  <= note_d;
            valid_q <= |keys_i;
        end
    end

    assign note_o       = note_q;
    assign note_valid_o = valid_q;

endmodule

// File: rtl/synth_ctrl.sv
// Control plane between keypad encoder and oscillator/envelope datapath:
// octave and waveform registers, last-note key arbitration, envelope gate FSM.
// Optional build macro SYNTH_CTRL_OCT_SATURATE_EN: octave saturates at the
// ends, and octave_pulse together with mode_pulse steps the octave down
// (wave_mode held that cycle). Without it the octave wraps and the two
// pulses act independently.
// Ports:
//   clk, n_rst               : clock, asynchronous active-low reset
//   octave_pulse, mode_pulse : single-cycle advance pulses
//   keys                     : synchronized key levels, 1 = pressed
//   octave, wave_mode        : current octave index / waveform selection
//   note, note_valid         : active note and "key held" flag
//   gate, releasing          : envelope gate (PLAY) / release phase (RELEASE)
module synth_ctrl
    import synth_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = NUM_KEYS_C,
    parameter int unsigned NUM_OCT        = NUM_OCT_C,
    parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_C,
    parameter int unsigned DEFAULT_OCT    = DEFAULT_OCT_C,
    parameter int unsigned OCT_W          = $clog2(NUM_OCT),
    parameter int unsigned NOTE_W         = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                octave_pulse,
    input  logic                mode_pulse,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [OCT_W-1:0]    octave,
    output logic [1:0]          wave_mode,
    output logic [NOTE_W-1:0]   note,
    output logic                note_valid,
    output logic                gate,
    output logic                releasing
);

    localparam int unsigned CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [OCT_W-1:0] OCT_MAX  = OCT_W'(NUM_OCT - 1);
    localparam logic [OCT_W-1:0] OCT_RST  = OCT_W'(DEFAULT_OCT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELEASE_CYCLES - 1);

    logic [OCT_W-1:0] oct_q, oct_d;
    wave_t            mode_q, mode_d;
    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_q, rel_q;
    logic             any_key;

    assign any_key = |keys;

    // Octave / waveform stepping.
    always_comb begin
        oct_d  = oct_q;
        mode_d = mode_q;
`ifdef SYNTH_CTRL_OCT_SATURATE_EN
        if (octave_pulse && mode_pulse) begin
            if (oct_q != '0) oct_d = oct_q - OCT_W'(1);
        end else if (octave_pulse) begin
            if (oct_q != OCT_MAX) oct_d = oct_q + OCT_W'(1);
        end else if (mode_pulse) begin
            mode_d = wave_t'(mode_q + 2'd1);
        end
`else
        if (octave_pulse) oct_d = (oct_q == OCT_MAX) ? '0 : oct_q + OCT_W'(1);
        if (mode_pulse)   mode_d = wave_t'(mode_q + 2'd1);
`endif
    end

    // Envelope gate sequencing; a press during release abandons the countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_key) state_d = PLAY;
            end
            PLAY: begin
                if (!any_key) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_LOAD;
                end
            end
            RELEASE: begin
                if (any_key) begin
                    state_d = PLAY;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            oct_q   <= OCT_RST;
            mode_q  <= SQUARE;
            state_q <= IDLE;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            oct_q   <= oct_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= (state_d == PLAY);
            rel_q   <= (state_d == RELEASE);
        end
    end

    note_arbiter #(
        .NUM_KEYS (NUM_KEYS),
        .NOTE_W   (NOTE_W)
    ) u_note_arbiter (
        .clk          (clk),
        .n_rst        (n_rst),
        .keys_i       (keys),
        .note_o       (note),
        .note_valid_o (note_valid)
    );

    assign octave    = oct_q;
    assign wave_mode = mode_q;
    assign gate      = gate_q;
    assign releasing = rel_q;

endmodule

// File: doc/synth_ctrl.md
Name: synth_ctrl

Overview:
- Control plane between the keypad front end and the oscillator/envelope datapath.
- Consumes single-cycle octave and mode pulses from the keypad encoder, plus synchronized note-key levels.
- Holds the current octave and waveform selection.
- Arbitrates the pressed keys down to one active note, with last-note priority.
- Sequences the envelope gate through IDLE, PLAY and RELEASE states.

Parameters:
- NUM_KEYS, 13: number of note keys (one octave, C to C).
- NUM_OCT, 8: number of selectable octaves, indices 0..NUM_OCT-1.
- RELEASE_CYCLES, 1024: clock cycles the gate stays in release after the last key is let go.
- DEFAULT_OCT, 4: octave loaded at reset.

Ports:
- clk, in, 1: system clock.
- n_rst, in, 1: asynchronous, active-low reset.
- octave_pulse, in, 1: one-cycle pulse; advance octave.
- mode_pulse, in, 1: one-cycle pulse; advance waveform mode.
- keys, in, NUM_KEYS: synchronized key levels, 1 = pressed.
- octave, out, $clog2(NUM_OCT): current octave index.
- wave_mode, out, 2: 0 = square, 1 = saw, 2 = triangle, 3 = sine.
- note, out, $clog2(NUM_KEYS): active note index.
- note_valid, out, 1: a key is currently held and note is meaningful.
- gate, out, 1: envelope gate, high in PLAY.
- releasing, out, 1: high in RELEASE.

Behaviour:
- Reset (n_rst low, asynchronous): octave=DEFAULT_OCT, wave_mode=0, note=0, note_valid=0, gate=0, releasing=0, FSM=IDLE, release counter=0, key history register=0.
- All outputs are registered. Each output updates on the clock edge after the causing input sample (latency 1).
- Octave:
  - Each octave_pulse increments octave.
  - NUM_OCT-1 wraps to 0 (subject to the optional feature).
  - Pulses never change note or gate.
- Mode:
  - Each mode_pulse increments wave_mode modulo 4.
  - octave_pulse and mode_pulse asserted in the same cycle both take effect.
- Key arbitration:
  - new_press = keys & ~keys_q, where keys_q is the previous-cycle keys.
  - If new_press is nonzero, note takes the highest-index bit of new_press.
  - Else, if keys[note] is still set, note holds.
  - Else, if any key is pressed, note takes the lowest-index pressed key (fallback).
  - note_valid = |keys, registered.
  - note holds its last value when no key is pressed.
- FSM states:
  - IDLE: gate=0, releasing=0. Any key pressed -> PLAY.
  - PLAY: gate=1. All keys released -> RELEASE, loading the counter with RELEASE_CYCLES-1.
  - RELEASE: gate=0, releasing=1.
    - Counter decrements each cycle; reaching 0 -> IDLE.
    - Any key pressed during RELEASE -> PLAY immediately; the counter is abandoned.
- Boundaries:
  - A key pressed and released in the same sample cannot occur (keys are levels).
  - A single-cycle key press enters PLAY, then RELEASE on the next cycle.
  - Reset mid-release returns to IDLE with the counter cleared.

Optional Feature:
- Macro: SYNTH_CTRL_OCT_SATURATE_EN.
- Defined:
  - octave_pulse with mode_pulse==0 increments, saturating at NUM_OCT-1.
  - octave_pulse with mode_pulse==1 in the same cycle decrements, saturating at 0; wave_mode does not change in that cycle.
- Undefined:
  - Octave increments with wrap.
  - Simultaneous pulses act independently, as above.

Decomposition:
- Package synth_pkg holds:
  - typedef enum for wave_t (SQUARE, SAW, TRI, SINE);
  - typedef enum for ctrl_state_t (IDLE, PLAY, RELEASE);
  - constants NUM_KEYS_C, NUM_OCT_C.
- One sub-module, note_arbiter: key history register, new-press detection and priority selection.
- The FSM, the octave/mode registers and the release counter stay in synth_ctrl.

Test Plan:
- Reset, then 4 octave_pulses -> octave 4,5,6,7,0 (macro off); with macro on, octave stays at 7.
- mode_pulse x5 -> wave_mode 1,2,3,0,1. Simultaneous octave+mode pulse with macro off -> both advance in that cycle.
- Press key 3, then key 9 while holding 3 -> note=3 then 9, gate=1. Release 9 -> note=3, gate stays 1.
- Press keys 2 and 7 in the same cycle -> note=7.
- Release all keys -> gate=0 and releasing=1 for exactly RELEASE_CYCLES cycles (use RELEASE_CYCLES=8), then IDLE with releasing=0.
- Re-press key 5 on release cycle 4 -> PLAY next cycle, gate=1, note=5. Then assert n_rst mid-RELEASE -> all outputs at reset values immediately, before the next clock edge.
